// File: rtl/serial_sub_ctrl_if.sv
// Handshake/data bundle for serial_sub_ctrl.
// The ovf signal is present only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, borrow, ovf);
  modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one bit per clock, LSB first, via two half subtractors.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_sub_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0]    S_IDLE = 2'd0;
  localparam logic [1:0]    S_RUN  = 2'd1;
  localparam logic [1:0]    S_DONE = 2'd2;
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             bin_q, bin_d, borrow_q, borrow_d;

  logic hs1_d_s, hs1_b_s, d_s, hs2_b_s, bout_s;

  // First half subtractor handles a - b, second subtracts the incoming borrow.
  assign hs1_d_s = a_q[0] ^ b_q[0];
  assign hs1_b_s = ~a_q[0] & b_q[0];
  assign d_s     = hs1_d_s ^ bin_q;
  assign hs2_b_s = ~hs1_d_s & bin_q;
  assign bout_s  = hs1_b_s | hs2_b_s;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d    = {1'b0, a_q[WIDTH-1:1]};
        b_d    = {1'b0, b_q[WIDTH-1:1]};
        diff_d = {d_s, diff_q[WIDTH-1:1]};
        bin_d  = bout_s;
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          borrow_d = bout_s;
`ifdef SERIAL_SUB_OVF_EN
          // d_s is the result MSB on this edge.
          ovf_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_s);
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl (WIDTH=8); define SERIAL_SUB_OVF_EN to cover ovf.
module tb_serial_sub_ctrl;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.WIDTH(WIDTH)) bus ();
  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
    int         acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  int   cyc      = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expected result for every done pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.done === 1'b1) begin
      n_done++;
      check("done_single_cycle", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done at cycle %0d with no pending request", cyc);
      end else begin
        e = sb.pop_front();
        check("diff", {24'd0, bus.diff}, {24'd0, e.diff});
        check("borrow", {31'd0, bus.borrow}, {31'd0, e.borrow});
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
`endif
        check("latency", cyc - e.acc_cyc, WIDTH);
      end
    end
    prev_done = bus.done;
  end

  task automatic wait_idle();
    int k = 0;
    while (bus.busy !== 1'b0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy still 1 after 40 cycles");
    end
  endtask

  task automatic wait_done();
    int k = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within 40 cycles");
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic eb, input logic eo);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{diff: ed, borrow: eb, ovf: eo, acc_cyc: cyc});
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb, input logic eo);
    wait_idle();
    issue(a, b, ed, eb, eo);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_done;
    exp_done  = 0;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_diff", {24'd0, bus.diff}, 32'd0);
    check("rst_borrow", {31'd0, bus.borrow}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif

    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
    exp_done += 4;

    // Back-to-back with start held high.
    wait_idle();
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{diff: 8'h00, borrow: 1'b0, ovf: 1'b0, acc_cyc: cyc});
    bus.a = 8'hFF;
    bus.b = 8'h01;
    for (int k = 0; k < 40 && bus.done !== 1'b1; k++) @(negedge clk);
    check("b2b_busy_in_done", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    check("b2b_busy_gap", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    sb.push_back('{diff: 8'hFE, borrow: 1'b0, ovf: 1'b0, acc_cyc: cyc});
    bus.start = 1'b0;
    check("b2b_busy_reaccept", {31'd0, bus.busy}, 32'd1);
    wait_done();
    exp_done += 2;

    // start during RUN is ignored.
    wait_idle();
    issue(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    bus.a     = 8'hAA;
    bus.b     = 8'h11;
    bus.start = 1'b1;
    @(negedge clk);
    check("ign_busy", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    wait_done();
    exp_done += 1;
    repeat (3) begin
      @(negedge clk);
      check("ign_no_requeue", {31'd0, bus.busy}, 32'd0);
    end

    // Reset four edges into RUN; start during rst is ignored.
    bus.a     = 8'h33;
    bus.b     = 8'h11;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'h44;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_diff", {24'd0, bus.diff}, 32'd0);
    check("abort_borrow", {31'd0, bus.borrow}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("abort_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
    repeat (12) @(negedge clk);
    run_op(8'h33, 8'h11, 8'h22, 1'b0, 1'b0);
    exp_done += 1;

`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op(8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0);
    exp_done += 2;
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    check("done_count", n_done, exp_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
